pc_seq: RTL

Parametrised program-counter sequencer for the CPU fetch stage, the next generation of the plain incrementing/loadable PC. Generalised in address width. Adds:
- signed relative branches;
- subroutine call/return via an internal return-address stack (RAS);
- sticky stack-fault reporting.

It sits between the control unit, which drives the op code, and instruction memory, which consumes pc.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_seq_if.sv | 31 +++
 rtl/pc_ras.sv | 45 ++++
 rtl/pc_seq.sv | 110 +++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: op encoding and
// the decode that folds reserved codes onto a defined behaviour.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_JMP  = 3'd2,
    OP_BR   = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } pc_op_e;

  // Codes 6 and 7 are unassigned; they execute as this op.
  localparam pc_op_e RESERVED_OP = OP_HOLD;

  function automatic pc_op_e op_decode(input logic [2:0] raw);
    if (raw > 3'd5) return RESERVED_OP;
    return pc_op_e'(raw);
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Control-unit <-> PC sequencer bundle. master = control unit, slave = pc_seq.
interface pc_seq_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] offset;
  logic             flt_clr;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] ret_addr;
  logic [DW-1:0]    depth;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             udf;

  modport master (
    output en, op, target, offset, flt_clr,
    input  pc, ret_addr, depth, full, empty, ovf, udf
  );

  modport slave (
    input  en, op, target, offset, flt_clr,
    output pc, ret_addr, depth, full, empty, ovf, udf
  );

endinterface

// File: rtl/pc_ras.sv
// Return-address stack: DEPTH x WIDTH registers, push/pop never together.
// Popped slots keep their contents; top reads 0 when the stack is empty.
module pc_ras #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [DW-1:0]    cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++)
        if (DW'(i) == cnt) stack[i] <= din;
      cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (DW'(i + 1) == cnt) top = stack[i];
  end

  assign depth = cnt;
  assign full  = (cnt == DW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/pc_seq.sv
// Fetch-stage program counter: increment, jump, relative branch,
// call/return through pc_ras, with sticky overflow/underflow flags.
module pc_seq
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input logic     clk,
  input logic     rst,
  pc_seq_if.slave bus
);

  localparam int DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]        pc_p0;
  logic [WIDTH-1:0]        pc_nxt;
  logic [WIDTH-1:0]        pc_inc;
  logic signed [WIDTH-1:0] offset_s;
  logic signed [WIDTH-1:0] br_sum;
  logic [WIDTH-1:0]        ras_top;
  logic [DW-1:0]           ras_depth;
  logic                    ras_full;
  logic                    ras_empty;
  logic                    push;
  logic                    pop;
  logic                    ovf_set;
  logic                    udf_set;
  logic                    ovf_p0;
  logic                    udf_p0;
  pc_op_e                  op_eff;

  assign op_eff   = op_decode(bus.op);
  assign pc_inc   = pc_p0 + 1'b1;
  assign offset_s = $signed(bus.offset);
  // Same-width two's-complement add: sign extension is implicit and the
  // carry out is discarded, giving the mod 2^WIDTH wrap.
  assign br_sum   = $signed(pc_p0) + offset_s;

  always_comb begin
    pc_nxt  = pc_p0;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (bus.en) begin
      case (op_eff)
        OP_INC: pc_nxt = pc_inc;
        OP_JMP: pc_nxt = bus.target;
        OP_BR:  pc_nxt = $unsigned(br_sum);
        OP_CALL: begin
          if (ras_full) begin
            ovf_set = 1'b1;
          end else begin
            push   = 1'b1;
            pc_nxt = bus.target;
          end
        end
        OP_RET: begin
          if (ras_empty) begin
            udf_set = 1'b1;
          end else begin
            pop    = 1'b1;
            pc_nxt = ras_top;
          end
        end
        default: pc_nxt = pc_p0;
      endcase
    end
  end

  // ---- stage p0: pc and sticky fault registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0  <= RESET_VEC;
      ovf_p0 <= 1'b0;
      udf_p0 <= 1'b0;
    end else begin
      pc_p0  <= pc_nxt;
      // Clear first, then set: a fault in the clearing cycle survives.
      ovf_p0 <= (ovf_p0 & ~bus.flt_clr) | ovf_set;
      udf_p0 <= (udf_p0 & ~bus.flt_clr) | udf_set;
    end
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (ras_top),
    .depth (ras_depth),
    .full  (ras_full),
    .empty (ras_empty)
  );

  assign bus.pc       = pc_p0;
  assign bus.ret_addr = ras_top;
  assign bus.depth    = ras_depth;
  assign bus.full     = ras_full;
  assign bus.empty    = ras_empty;
  assign bus.ovf      = ovf_p0;
  assign bus.udf      = udf_p0;

endmodule
